// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan_decoder block.
package scan_decoder_pkg;

    typedef enum logic [1:0] {StIdle, StDirect, StScan} state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_if.sv
// Control and strobe bundle for scan_decoder; master drives controls, slave drives strobes.
interface scan_decoder_if #(
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned DWELL_W = 8
);
    logic                  en;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic                  sel_valid;
    logic                  sel_ready;
    logic [DWELL_W-1:0]    dwell;
    logic [SEL_W-1:0]      last_row;
    logic [2**SEL_W-1:0]   y;
    logic [SEL_W-1:0]      idx;
    logic                  y_valid;
    logic                  wrap;

    modport master (
        output en, mode, sel, sel_valid, dwell, last_row,
        input  sel_ready, y, idx, y_valid, wrap
    );

    modport slave (
        input  en, mode, sel, sel_valid, dwell, last_row,
        output sel_ready, y, idx, y_valid, wrap
    );
endinterface

// File: rtl/onehot_dec.sv
// Combinational enable-gated binary to one-hot decoder.
module onehot_dec #(
    parameter int unsigned SEL_W = 4
) (
    input  logic                en_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic [2**SEL_W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot row decoder with DIRECT (handshaked select) and SCAN (auto-step) modes.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned DWELL_W    = 8,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    scan_decoder_if.slave dec_if
);

    localparam int unsigned OUT_N = 2**SEL_W;

    state_t               state_q, state_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0]   cfg_dwell_q, cfg_dwell_d;
    logic [SEL_W-1:0]     cfg_last_q, cfg_last_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic                 y_valid_q, y_valid_d;
    logic                 wrap_q, wrap_d;
    logic [OUT_N-1:0]     onehot_q, onehot_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_dwell_d = cfg_dwell_q;
        cfg_last_d  = cfg_last_q;
        idx_d       = idx_q;
        y_valid_d   = y_valid_q;
        wrap_d      = 1'b0;

        if (!dec_if.en) begin
            state_d   = StIdle;
            y_valid_d = 1'b0;
            cnt_d     = '0;
        end else if (dec_if.mode == MODE_DIRECT) begin
            state_d = StDirect;
            if (state_q != StDirect) begin
                // Blank on entry; sel_ready only rises once the state is DIRECT.
                y_valid_d = 1'b0;
            end else if (dec_if.sel_valid) begin
                idx_d     = dec_if.sel;
                y_valid_d = 1'b1;
            end
        end else begin
            state_d = StScan;
            if (state_q != StScan) begin
                cfg_dwell_d = dec_if.dwell;
                cfg_last_d  = dec_if.last_row;
                cnt_d       = '0;
                idx_d       = '0;
                y_valid_d   = 1'b1;
            end else if (cnt_q == cfg_dwell_q) begin
                cnt_d = '0;
                if (idx_q == cfg_last_q) begin
                    // Frame boundary: the only point where new dwell/last_row are sampled.
                    idx_d       = '0;
                    wrap_d      = 1'b1;
                    cfg_dwell_d = dec_if.dwell;
                    cfg_last_d  = dec_if.last_row;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .en_i  (y_valid_d),
        .sel_i (idx_d),
        .y_o   (onehot_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cfg_dwell_q <= '0;
            cfg_last_q  <= '0;
            idx_q       <= '0;
            y_valid_q   <= 1'b0;
            wrap_q      <= 1'b0;
            onehot_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_dwell_q <= cfg_dwell_d;
            cfg_last_q  <= cfg_last_d;
            idx_q       <= idx_d;
            y_valid_q   <= y_valid_d;
            wrap_q      <= wrap_d;
            onehot_q    <= onehot_d;
        end
    end

    assign dec_if.sel_ready = dec_if.en & (state_q == StDirect);
    assign dec_if.y         = onehot_q ^ {OUT_N{ACTIVE_LOW}};
    assign dec_if.idx       = idx_q;
    assign dec_if.y_valid   = y_valid_q;
    assign dec_if.wrap      = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: DIRECT vector table plus hand-written SCAN sequences.
module tb_scan_decoder;

    logic clk;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;

    scan_decoder_if #(.SEL_W(4), .DWELL_W(8)) bus ();
    scan_decoder_if #(.SEL_W(3), .DWELL_W(8)) al_bus ();

    scan_decoder #(.SEL_W(4), .DWELL_W(8), .ACTIVE_LOW(1'b0)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dec_if (bus.slave)
    );

    scan_decoder #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b1)) u_dut_al (
        .clk    (clk),
        .rst_n  (rst_n),
        .dec_if (al_bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        en;
        logic        mode;
        logic [3:0]  sel;
        logic        sv;
        logic [15:0] y;
        logic [3:0]  idx;
        logic        vld;
        logic        rdy;
    } vec_t;

    vec_t dir_tab[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input logic [7:0] dw, input logic [3:0] lr);
        bus.en = 1'b0;
        tick();
        bus.en       = 1'b1;
        bus.mode     = 1'b1;
        bus.dwell    = dw;
        bus.last_row = lr;
        bus.sel      = 4'd7;
        bus.sel_valid = 1'b1;
    endtask

    initial begin
        logic [15:0] ey;
        int          row;

        rst_n = 1'b1;
        bus.en = 1'b0; bus.mode = 1'b0; bus.sel = '0; bus.sel_valid = 1'b0;
        bus.dwell = '0; bus.last_row = '0;
        al_bus.en = 1'b0; al_bus.mode = 1'b0; al_bus.sel = '0; al_bus.sel_valid = 1'b0;
        al_bus.dwell = '0; al_bus.last_row = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.y", 32'(bus.y), 32'h0);
        chk("rst.idx", 32'(bus.idx), 32'h0);
        chk("rst.y_valid", 32'(bus.y_valid), 32'h0);
        chk("rst.wrap", 32'(bus.wrap), 32'h0);
        chk("rst.sel_ready", 32'(bus.sel_ready), 32'h0);
        chk("al.rst.y", 32'(al_bus.y), 32'hFF);
        rst_n = 1'b1;

        // DIRECT table: one vector per cycle, outputs checked after the edge.
        dir_tab[0]  = '{1'b1, 1'b0, 4'd9,  1'b1, 16'h0000, 4'd0,  1'b0, 1'b1};
        dir_tab[1]  = '{1'b1, 1'b0, 4'd9,  1'b1, 16'h0200, 4'd9,  1'b1, 1'b1};
        dir_tab[2]  = '{1'b1, 1'b0, 4'd3,  1'b0, 16'h0200, 4'd9,  1'b1, 1'b1};
        dir_tab[3]  = '{1'b1, 1'b0, 4'd3,  1'b0, 16'h0200, 4'd9,  1'b1, 1'b1};
        dir_tab[4]  = '{1'b1, 1'b0, 4'd3,  1'b0, 16'h0200, 4'd9,  1'b1, 1'b1};
        dir_tab[5]  = '{1'b1, 1'b0, 4'd3,  1'b0, 16'h0200, 4'd9,  1'b1, 1'b1};
        dir_tab[6]  = '{1'b1, 1'b0, 4'd3,  1'b0, 16'h0200, 4'd9,  1'b1, 1'b1};
        dir_tab[7]  = '{1'b1, 1'b0, 4'd0,  1'b1, 16'h0001, 4'd0,  1'b1, 1'b1};
        dir_tab[8]  = '{1'b1, 1'b0, 4'd15, 1'b1, 16'h8000, 4'd15, 1'b1, 1'b1};
        dir_tab[9]  = '{1'b0, 1'b0, 4'd5,  1'b1, 16'h0000, 4'd15, 1'b0, 1'b0};
        dir_tab[10] = '{1'b1, 1'b0, 4'd5,  1'b1, 16'h0000, 4'd15, 1'b0, 1'b1};
        dir_tab[11] = '{1'b1, 1'b0, 4'd5,  1'b1, 16'h0020, 4'd5,  1'b1, 1'b1};

        al_bus.en = 1'b1; al_bus.mode = 1'b0; al_bus.sel = 3'd5; al_bus.sel_valid = 1'b1;

        for (int i = 0; i < 12; i++) begin
            bus.en = dir_tab[i].en; bus.mode = dir_tab[i].mode;
            bus.sel = dir_tab[i].sel; bus.sel_valid = dir_tab[i].sv;
            tick();
            chk($sformatf("dir[%0d].y", i), 32'(bus.y), 32'(dir_tab[i].y));
            chk($sformatf("dir[%0d].idx", i), 32'(bus.idx), 32'(dir_tab[i].idx));
            chk($sformatf("dir[%0d].y_valid", i), 32'(bus.y_valid), 32'(dir_tab[i].vld));
            chk($sformatf("dir[%0d].sel_ready", i), 32'(bus.sel_ready), 32'(dir_tab[i].rdy));
        end
        chk("al.direct.y", 32'(al_bus.y), 32'hDF);
        chk("al.direct.idx", 32'(al_bus.idx), 32'h5);

        // SCAN dwell=2 last_row=3: 3 cycles per row, wrap every 12 cycles from cycle 13.
        start_scan(8'd2, 4'd3);
        for (int k = 1; k <= 26; k++) begin
            tick();
            row = ((k - 1) / 3) % 4;
            ey  = 16'h1 << row;
            chk($sformatf("scan[%0d].y", k), 32'(bus.y), 32'(ey));
            chk($sformatf("scan[%0d].idx", k), 32'(bus.idx), 32'(row));
            chk($sformatf("scan[%0d].wrap", k), 32'(bus.wrap), 32'(k > 1 && (k - 1) % 12 == 0));
            chk($sformatf("scan[%0d].sel_ready", k), 32'(bus.sel_ready), 32'h0);
        end

        // last_row changed mid-frame only applies from the next frame.
        start_scan(8'd2, 4'd3);
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k == 4) bus.last_row = 4'd1;
            row = (k <= 12) ? (k - 1) / 3 : ((k - 13) / 3) % 2;
            chk($sformatf("frm[%0d].idx", k), 32'(bus.idx), 32'(row));
            chk($sformatf("frm[%0d].wrap", k), 32'(bus.wrap), 32'(k == 13 || k == 19));
        end

        // Mode change mid-row, then return to SCAN restarts at row 0.
        start_scan(8'd2, 4'd3);
        repeat (7) tick();
        chk("mode.scan_idx", 32'(bus.idx), 32'h2);
        bus.mode = 1'b0; bus.sel = 4'd4; bus.sel_valid = 1'b1;
        tick();
        chk("mode.entry_y", 32'(bus.y), 32'h0);
        chk("mode.entry_valid", 32'(bus.y_valid), 32'h0);
        chk("mode.entry_ready", 32'(bus.sel_ready), 32'h1);
        tick();
        chk("mode.accept_y", 32'(bus.y), 32'h0010);
        bus.mode = 1'b1;
        tick();
        chk("mode.rescan_y", 32'(bus.y), 32'h0001);
        chk("mode.rescan_idx", 32'(bus.idx), 32'h0);
        chk("mode.rescan_ready", 32'(bus.sel_ready), 32'h0);
        tick();
        bus.en = 1'b0;
        tick();
        chk("en0.y", 32'(bus.y), 32'h0);
        chk("en0.y_valid", 32'(bus.y_valid), 32'h0);

        // Full 16-row frame with dwell=0: idx wraps 15 -> 0.
        start_scan(8'd0, 4'd15);
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk($sformatf("full[%0d].idx", k), 32'(bus.idx), 32'((k - 1) % 16));
            chk($sformatf("full[%0d].wrap", k), 32'(bus.wrap), 32'(k == 17));
        end

        // last_row=0, dwell=1: row 0 only, wrap every 2 cycles after the first dwell.
        start_scan(8'd1, 4'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("row0[%0d].y", k), 32'(bus.y), 32'h0001);
            chk($sformatf("row0[%0d].wrap", k), 32'(bus.wrap), 32'(k > 1 && (k - 1) % 2 == 0));
        end

        // Asynchronous reset while wrap is high, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("arst.y", 32'(bus.y), 32'h0);
        chk("arst.y_valid", 32'(bus.y_valid), 32'h0);
        chk("arst.wrap", 32'(bus.wrap), 32'h0);
        chk("arst.sel_ready", 32'(bus.sel_ready), 32'h0);
        chk("arst.al_y", 32'(al_bus.y), 32'hFF);
        bus.mode = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("arst.idle_ready", 32'(bus.sel_ready), 32'h0);
        tick();
        chk("arst.direct_ready", 32'(bus.sel_ready), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
